// File: rtl/vend_txn_ctrl_if.sv
// Customer/dispenser signal bundle for the vending transaction controller.
// master drives the customer and dispenser inputs; slave is the controller side.
interface vend_txn_ctrl_if;
  logic       coin_valid;
  logic [2:0] coin_val;
  logic       sel_valid;
  logic [1:0] sel_item;
  logic [3:0] price;
  logic       cancel;
  logic       dispense_ack;
  logic [4:0] credit;
  logic       vend_req;
  logic [1:0] vend_item;
  logic       change_valid;
  logic [4:0] change;
  logic       coin_reject;
  logic       busy;

  modport master (
    output coin_valid, coin_val, sel_valid, sel_item, price, cancel, dispense_ack,
    input  credit, vend_req, vend_item, change_valid, change, coin_reject, busy
  );

  modport slave (
    input  coin_valid, coin_val, sel_valid, sel_item, price, cancel, dispense_ack,
    output credit, vend_req, vend_item, change_valid, change, coin_reject, busy
  );
endinterface

// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: coin collection, item selection, dispense and change return.
// Define VEND_TIMEOUT_EN to make COLLECT auto-cancel after TIMEOUT_CYCLES idle cycles.
module vend_txn_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 200
) (
  input logic            clk,
  input logic            rst,
  vend_txn_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCollect, StVend, StChange} state_e;

  state_e     r_state, w_state;
  logic [4:0] r_credit, w_credit;
  logic       r_sel, w_sel;
  logic [1:0] r_item, w_item;
  logic [3:0] r_price, w_price;
  logic       r_vend_req, w_vend_req;
  logic [1:0] r_vend_item, w_vend_item;
  logic       r_change_valid, w_change_valid;
  logic [4:0] r_change, w_change;
  logic       r_coin_reject, w_coin_reject;
  logic       r_busy;

  logic [5:0] w_coin_sum;
  logic       w_coin_fits;
  logic       w_sel_ok;
  logic       w_can_vend;
  logic [4:0] w_after_vend;
  logic       w_timeout;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  assign w_coin_sum   = {1'b0, r_credit} + {3'b000, bus.coin_val};
  assign w_coin_fits  = ~w_coin_sum[5];
  assign w_sel_ok     = bus.sel_valid && (bus.price != 4'd0);
  // Vend decision looks only at registered credit/price, one cycle after they settle.
  assign w_can_vend   = r_sel && (r_credit >= {1'b0, r_price});
  assign w_after_vend = r_credit - {1'b0, r_price};

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] r_to_cnt, w_to_cnt;
  logic            w_activity;

  assign w_activity = bus.coin_valid | bus.sel_valid;
  assign w_timeout  = (r_state == StCollect) && !w_activity &&
                      (r_to_cnt == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_to_cnt = '0;
    if ((r_state == StCollect) && (w_state == StCollect) && !w_activity) begin
      w_to_cnt = r_to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= w_to_cnt;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state        = r_state;
    w_credit       = r_credit;
    w_sel          = r_sel;
    w_item         = r_item;
    w_price        = r_price;
    w_vend_req     = 1'b0;
    w_vend_item    = r_vend_item;
    w_change_valid = 1'b0;
    w_change       = r_change;
    w_coin_reject  = 1'b0;
    case (r_state)
      StIdle: begin
        // Credit is always zero here, so a coin can never overflow.
        if (bus.coin_valid && (bus.coin_val != 3'd0)) begin
          w_credit = w_coin_sum[4:0];
          w_state  = StCollect;
        end
        if (w_sel_ok) begin
          w_sel   = 1'b1;
          w_item  = bus.sel_item;
          w_price = bus.price;
          w_state = StCollect;
        end
      end
      StCollect: begin
        if (bus.cancel || w_timeout) begin
          w_coin_reject  = bus.coin_valid;
          w_change_valid = (r_credit != 5'd0);
          w_change       = r_credit;
          w_state        = StChange;
        end else begin
          if (bus.coin_valid) begin
            if (w_coin_fits) begin
              w_credit = w_coin_sum[4:0];
            end else begin
              w_coin_reject = 1'b1;
            end
          end
          if (w_can_vend) begin
            w_vend_req  = 1'b1;
            w_vend_item = r_item;
            w_state     = StVend;
          end else if (w_sel_ok) begin
            w_sel   = 1'b1;
            w_item  = bus.sel_item;
            w_price = bus.price;
          end
        end
      end
      StVend: begin
        w_coin_reject = bus.coin_valid;
        if (bus.dispense_ack) begin
          w_credit       = w_after_vend;
          w_change_valid = (w_after_vend != 5'd0);
          w_change       = w_after_vend;
          w_state        = StChange;
        end else begin
          w_vend_req = 1'b1;
        end
      end
      StChange: begin
        w_coin_reject = bus.coin_valid;
        w_credit      = 5'd0;
        w_sel         = 1'b0;
        w_item        = 2'd0;
        w_price       = 4'd0;
        w_state       = StIdle;
      end
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= StIdle;
      r_credit       <= 5'd0;
      r_sel          <= 1'b0;
      r_item         <= 2'd0;
      r_price        <= 4'd0;
      r_vend_req     <= 1'b0;
      r_vend_item    <= 2'd0;
      r_change_valid <= 1'b0;
      r_change       <= 5'd0;
      r_coin_reject  <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_credit       <= w_credit;
      r_sel          <= w_sel;
      r_item         <= w_item;
      r_price        <= w_price;
      r_vend_req     <= w_vend_req;
      r_vend_item    <= w_vend_item;
      r_change_valid <= w_change_valid;
      r_change       <= w_change;
      r_coin_reject  <= w_coin_reject;
      r_busy         <= (w_state != StIdle);
    end
  end

  assign bus.credit       = r_credit;
  assign bus.vend_req     = r_vend_req;
  assign bus.vend_item    = r_vend_item;
  assign bus.change_valid = r_change_valid;
  assign bus.change       = r_change;
  assign bus.coin_reject  = r_coin_reject;
  assign bus.busy         = r_busy;

endmodule

// File: doc/vend_txn_ctrl.md
VEND_TXN_CTRL -- requirements
Module: vend_txn_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 200, inactivity limit in clk cycles (used only with VEND_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port coin_valid  input  1  one-cycle coin-insert strobe.
REQ-005 SHALL have port coin_val  input  3  coin value in credit units (0..7).
REQ-006 SHALL have port sel_valid  input  1  one-cycle item-selection strobe.
REQ-007 SHALL have port sel_item  input  2  selected item index.
REQ-008 SHALL have port price  input  4  price of sel_item, sampled with sel_valid.
REQ-009 SHALL have port cancel  input  1  one-cycle customer cancel strobe.
REQ-010 SHALL have port dispense_ack  input  1  dispenser completion acknowledge.
REQ-011 SHALL have port credit  output  5  current accumulated credit.
REQ-012 SHALL have port vend_req  output  1  dispense request, level, held until acknowledged.
REQ-013 SHALL have port vend_item  output  2  latched item index, valid while vend_req=1.
REQ-014 SHALL have port change_valid  output  1  one-cycle change-return strobe.
REQ-015 SHALL have port change  output  5  change amount, valid with change_valid.
REQ-016 SHALL have port coin_reject  output  1  one-cycle strobe: coin not accepted.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, COLLECT, VEND, CHANGE; all outputs registered.
REQ-019 IDLE: accepted coin adds coin_val to credit and moves to COLLECT; sel_valid with price!=0 latches item/price and moves to COLLECT.
REQ-020 sel_valid with price==0 SHALL be ignored in every state.
REQ-021 COLLECT: coins add to credit; a later sel_valid replaces the latched item/price; simultaneous coin and selection both accepted.
REQ-022 Credit SHALL never exceed 31: a coin with credit+coin_val>31 is not added and coin_reject pulses next cycle.
REQ-023 COLLECT: when a selection is latched and registered credit >= latched price, next state SHALL be VEND (vend_req high one cycle after the credit/price update edge).
REQ-024 COLLECT: cancel SHALL move to CHANGE with change=credit; cancel wins over same-cycle coin (coin rejected) and selection (ignored).
REQ-025 VEND: vend_req=1, vend_item=latched item; coins rejected; cancel and sel_valid ignored.
REQ-026 VEND: on dispense_ack, credit SHALL become credit-price (no underflow possible) and state CHANGE.
REQ-027 CHANGE: one cycle; if credit!=0 change_valid=1 and change=credit, else no strobe; then IDLE with credit=0 and selection cleared.
REQ-028 dispense_ack outside VEND SHALL be ignored.
REQ-029 coin_val==0 coins SHALL be accepted as no-ops (no reject, no state change).

Reset
REQ-030 rst SHALL force IDLE, credit=0, vend_req=0, vend_item=0, change_valid=0, change=0, coin_reject=0, busy=0, selection cleared, timeout counter 0.
REQ-031 rst mid-VEND SHALL drop vend_req next cycle with no change strobe; rst has priority over all inputs.

Configuration
REQ-032 Macro VEND_TIMEOUT_EN defined: in COLLECT, counter increments each cycle without coin_valid/sel_valid, clears on either; reaching TIMEOUT_CYCLES SHALL act as cancel (go CHANGE, return credit).
REQ-033 Macro VEND_TIMEOUT_EN undefined: no counter logic; COLLECT persists until cancel or vend condition.

Verification
REQ-034 Select item 2 price 7, coins 5 then 5 -> vend_req=1, vend_item=2; ack -> change_valid=1, change=3; then IDLE, credit=0.
REQ-035 Coins totalling 30, coin 5 -> coin_reject pulse, credit stays 30; cancel -> change=30.
REQ-036 Coin 4 and cancel same cycle in COLLECT (credit 6) -> coin_reject, change=6.
REQ-037 Exact payment price 6, coins 3+3, ack -> no change_valid, return to IDLE.
REQ-038 rst asserted while vend_req=1 -> vend_req=0, credit=0, IDLE next cycle, no change strobe.
REQ-039 With VEND_TIMEOUT_EN, TIMEOUT_CYCLES=10, coin 4 then idle 10 cycles -> change_valid=1, change=4; without macro -> stays COLLECT.
